pixel_forward_ctrl: RTL and testbench

Sequencing controller between the bit decoder and the output reshaper in the LED-chain pipeline. Consumes decoded bits (`shift_reg_t`), captures the first `BITS_PER_PIXEL` bits after each reset as this node's pixel, and then gates every following bit to the reshaper (`reshaper_t`) for the downstream node. The captured pixel is latched to the output on the next reset, not before. The block also keeps a saturating count of forwarded bits for debug.

---
 rtl/pipeline_types.sv | 23 ++
 rtl/pixel_forward_ctrl.sv | 128 ++++++++++++
 tb/tb_pixel_forward_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_types.sv
// Shared types for the LED-chain pipeline: decoder-to-controller bit stream,
// controller-to-reshaper strobe and the pixel forwarding controller state.
package pipeline_types;

    typedef struct packed {
        logic valid;
        logic treset;
        logic decoded_bit;
    } shift_reg_t;

    typedef struct packed {
        logic enable;
        logic decoded_bit;
    } reshaper_t;

    typedef enum logic [0:0] {
        ST_CAPTURE = 1'b0,
        ST_FORWARD = 1'b1
    } fwd_state_t;

    localparam reshaper_t RESET_VALUES_RESHAPER = '{enable: 1'b0, decoded_bit: 1'b0};

endpackage

// File: rtl/pixel_forward_ctrl.sv
// Captures the first BITS_PER_PIXEL bits after each line reset as this node's
// pixel, forwards all later bits to the reshaper, and latches the pixel on reset.
module pixel_forward_ctrl
    import pipeline_types::*;
#(
    parameter int BITS_PER_PIXEL = 24,
    parameter int FWD_CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  shift_reg_t                i_bit,
    output reshaper_t                 o_reshaper,
    output logic [BITS_PER_PIXEL-1:0] o_pixel,
    output logic                      o_pixel_valid,
    output logic                      o_forwarding,
    output logic [FWD_CNT_W-1:0]      o_fwd_count
);

    localparam int                CNT_W    = $clog2(BITS_PER_PIXEL + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(BITS_PER_PIXEL);
    localparam logic [FWD_CNT_W-1:0] SAT_CNT = {FWD_CNT_W{1'b1}};

    fwd_state_t                state_r;
    fwd_state_t                state_nxt_s;
    logic [BITS_PER_PIXEL-1:0] cap_r;
    logic [CNT_W-1:0]          bit_cnt_r;
    logic                      capture_s;
    logic                      forward_s;
    logic                      full_s;

    // Next-state and strobe decode; a line reset overrides any bit in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        forward_s   = 1'b0;
        full_s      = (bit_cnt_r == FULL_CNT);
        if (i_bit.treset) begin
            state_nxt_s = ST_CAPTURE;
        end else if (i_bit.valid) begin
            case (state_r)
                ST_CAPTURE: begin
                    capture_s = 1'b1;
                    if (bit_cnt_r == (FULL_CNT - CNT_W'(1))) begin
                        state_nxt_s = ST_FORWARD;
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                    end
                end
                ST_FORWARD: begin
                    forward_s = 1'b1;
                end
                default: begin
                    state_nxt_s = ST_CAPTURE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state with its registered forwarding flag and reshaper strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_CAPTURE;
            o_forwarding <= 1'b0;
            o_reshaper   <= RESET_VALUES_RESHAPER;
        end else begin
            state_r                <= state_nxt_s;
            o_forwarding           <= (state_nxt_s == ST_FORWARD);
            o_reshaper.enable      <= forward_s;
            o_reshaper.decoded_bit <= forward_s ? i_bit.decoded_bit : 1'b0;
        end
    end

    // Capture shift register, MSB of the pixel arrives first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_r <= '0;
        end else if (i_bit.treset) begin
            cap_r <= '0;
        end else if (capture_s) begin
            cap_r <= {cap_r[BITS_PER_PIXEL-2:0], i_bit.decoded_bit};
        end else begin
            cap_r <= cap_r;
        end
    end

    // Captured-bit counter; stays at full while forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= '0;
        end else if (i_bit.treset) begin
            bit_cnt_r <= '0;
        end else if (capture_s) begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Saturating debug count of forwarded bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_fwd_count <= '0;
        end else if (i_bit.treset) begin
            o_fwd_count <= '0;
        end else if (forward_s && (o_fwd_count != SAT_CNT)) begin
            o_fwd_count <= o_fwd_count + FWD_CNT_W'(1);
        end else begin
            o_fwd_count <= o_fwd_count;
        end
    end

    // Displayed pixel updates only on a line reset that follows a full capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pixel       <= '0;
            o_pixel_valid <= 1'b0;
        end else if (i_bit.treset && full_s) begin
            o_pixel       <= cap_r;
            o_pixel_valid <= 1'b1;
        end else begin
            o_pixel       <= o_pixel;
            o_pixel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_forward_ctrl.sv
// Scoreboard bench for pixel_forward_ctrl: a reference model queues expected
// forwarded bits and latched pixels; a negedge monitor checks every DUT response.
module tb_pixel_forward_ctrl;
    import pipeline_types::*;

    localparam int BPP = 24;

    logic        clk;
    logic        rst_n;
    shift_reg_t  i_bit;
    reshaper_t   o_reshaper;
    logic [23:0] o_pixel;
    logic        o_pixel_valid;
    logic        o_forwarding;
    logic [15:0] o_fwd_count;

    reshaper_t   sm_reshaper;
    logic [23:0] sm_pixel;
    logic        sm_pixel_valid;
    logic        sm_forwarding;
    logic [3:0]  sm_fwd_count;

    pixel_forward_ctrl #(.BITS_PER_PIXEL(BPP), .FWD_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_bit(i_bit),
        .o_reshaper(o_reshaper), .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid),
        .o_forwarding(o_forwarding), .o_fwd_count(o_fwd_count)
    );

    pixel_forward_ctrl #(.BITS_PER_PIXEL(BPP), .FWD_CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_bit(i_bit),
        .o_reshaper(sm_reshaper), .o_pixel(sm_pixel), .o_pixel_valid(sm_pixel_valid),
        .o_forwarding(sm_forwarding), .o_fwd_count(sm_fwd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_en    = 0;
    int n_pv    = 0;

    logic        bit_q[$];
    logic [23:0] pix_q[$];
    int          m_bits;
    logic [23:0] m_cap;
    logic        m_fwd;
    int          m_cnt;
    logic [23:0] m_pixel;
    logic        mon_en;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_bits = 0;
        m_cap  = 24'h0;
        m_fwd  = 1'b0;
        m_cnt  = 0;
    endtask

    // One input cycle; the model advances at the same edge the DUT samples.
    task automatic drive(input logic v, input logic b, input logic t);
        i_bit.valid       = v;
        i_bit.decoded_bit = b;
        i_bit.treset      = t;
        @(posedge clk);
        if (t) begin
            if (m_bits == BPP) begin
                pix_q.push_back(m_cap);
                m_pixel = m_cap;
            end
            model_clear();
        end else if (v) begin
            if (!m_fwd) begin
                m_cap = {m_cap[22:0], b};
                m_bits++;
                if (m_bits == BPP) m_fwd = 1'b1;
            end else begin
                bit_q.push_back(b);
                if (m_cnt != 65535) m_cnt++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_pixel(input logic [23:0] p);
        for (int i = 23; i >= 0; i--) drive(1'b1, p[i], 1'b0);
    endtask

    task automatic send_bits(input logic [23:0] p, input int n);
        for (int i = 23; i > 23 - n; i--) drive(1'b1, p[i], 1'b0);
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (o_reshaper.enable) begin
                n_en++;
                if (bit_q.size() == 0) check_val("enable_unexpected", 32'd1, 32'd0);
                else check_val("fwd_bit", {31'd0, o_reshaper.decoded_bit}, {31'd0, bit_q.pop_front()});
            end
            if (o_pixel_valid) begin
                n_pv++;
                if (pix_q.size() == 0) check_val("pixel_valid_unexpected", 32'd1, 32'd0);
                else check_val("latched_pixel", {8'd0, o_pixel}, {8'd0, pix_q.pop_front()});
            end
            check_val("pixel_hold", {8'd0, o_pixel}, {8'd0, m_pixel});
            check_val("forwarding", {31'd0, o_forwarding}, {31'd0, m_fwd});
            check_val("fwd_count", {16'd0, o_fwd_count}, m_cnt);
            check_val("fwd_count_w4", {28'd0, sm_fwd_count}, (m_cnt > 15) ? 32'd15 : m_cnt);
        end
    end

    int en_mark;
    int pv_mark;

    initial begin
        mon_en  = 1'b0;
        i_bit   = '0;
        m_pixel = 24'h0;
        model_clear();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_enable", {31'd0, o_reshaper.enable}, 32'd0);
        check_val("rst_pixel", {8'd0, o_pixel}, 32'd0);
        check_val("rst_pixel_valid", {31'd0, o_pixel_valid}, 32'd0);
        check_val("rst_forwarding", {31'd0, o_forwarding}, 32'd0);
        check_val("rst_fwd_count", {16'd0, o_fwd_count}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Single pixel, no forwarding.
        en_mark = n_en; pv_mark = n_pv;
        send_pixel(24'hA5C3F0);
        drive(1'b0, 1'b0, 1'b1);
        check_val("t1_pixel", {8'd0, o_pixel}, 32'hA5C3F0);
        check_val("t1_pulse_now", {31'd0, o_pixel_valid}, 32'd1);
        idle(1);
        check_val("t1_pulse_gone", {31'd0, o_pixel_valid}, 32'd0);
        check_val("t1_no_enable", n_en - en_mark, 32'd0);
        check_val("t1_one_pulse", n_pv - pv_mark, 32'd1);
        idle(2);

        // Three pixels back to back; two are forwarded.
        en_mark = n_en;
        send_pixel(24'h112233);
        send_pixel(24'h445566);
        send_pixel(24'h778899);
        check_val("t2_cnt_before", {16'd0, o_fwd_count}, 32'd48);
        drive(1'b0, 1'b0, 1'b1);
        check_val("t2_pixel", {8'd0, o_pixel}, 32'h112233);
        check_val("t2_cnt_after", {16'd0, o_fwd_count}, 32'd0);
        check_val("t2_sat_cnt", {28'd0, sm_fwd_count}, 32'd0);
        check_val("t2_enables", n_en - en_mark, 32'd48);
        idle(2);

        // Partial capture is discarded, then a fresh capture.
        pv_mark = n_pv;
        send_bits(24'h3C3C3C, 10);
        drive(1'b0, 1'b0, 1'b1);
        idle(1);
        check_val("t3_pixel_kept", {8'd0, o_pixel}, 32'h112233);
        check_val("t3_no_pulse", n_pv - pv_mark, 32'd0);
        send_pixel(24'h5A5A01);
        drive(1'b0, 1'b0, 1'b1);
        check_val("t3_fresh", {8'd0, o_pixel}, 32'h5A5A01);
        idle(2);

        // treset together with the 31st bit drops that bit.
        en_mark = n_en;
        send_pixel(24'hC0FFEE);
        send_bits(24'hDE0000, 6);
        drive(1'b1, 1'b1, 1'b1);
        check_val("t4_enable_low", {31'd0, o_reshaper.enable}, 32'd0);
        check_val("t4_capture_state", {31'd0, o_forwarding}, 32'd0);
        check_val("t4_enables", n_en - en_mark, 32'd6);
        check_val("t4_pixel", {8'd0, o_pixel}, 32'hC0FFEE);
        idle(2);

        // 20 forwarded bits saturate the narrow counter.
        send_pixel(24'h0F0F0F);
        send_bits(24'hFFFFF0, 20);
        check_val("t5_sat15", {28'd0, sm_fwd_count}, 32'd15);
        idle(2);
        check_val("t5_hold15", {28'd0, sm_fwd_count}, 32'd15);
        drive(1'b0, 1'b0, 1'b1);
        idle(2);

        // Asynchronous reset in mid-frame.
        send_bits(24'hFFF000, 12);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #2;
        check_val("t6_async_pixel", {8'd0, o_pixel}, 32'd0);
        model_clear();
        m_pixel = 24'h0;
        bit_q.delete();
        pix_q.delete();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(1);
        send_pixel(24'h13579B);
        drive(1'b0, 1'b0, 1'b1);
        check_val("t6_pixel", {8'd0, o_pixel}, 32'h13579B);
        idle(2);

        mon_en = 1'b0;
        check_val("bitq_drained", bit_q.size(), 32'd0);
        check_val("pixq_drained", pix_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
